// File: rtl/dpram_arb_pkg.sv
// Shared constants, types and helpers for the dual-port RAM port arbiter.
package dpram_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 6;
    localparam int IDX_W   = $clog2(NUM_REQ);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [IDX_W-1:0]  idx_t;

    // Tag carried for one cycle alongside each RAM port: was it a read, and for whom.
    typedef struct packed {
        logic vld;
        idx_t idx;
    } port_tag_t;

    // Next requester index in circular order.
    function automatic idx_t idx_inc(idx_t i);
        if (int'(i) == NUM_REQ - 1) begin
            return '0;
        end
        return i + idx_t'(1);
    endfunction

    // One-hot vector selecting a single requester.
    function automatic logic [NUM_REQ-1:0] idx_onehot(idx_t i);
        logic [NUM_REQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Requester-side bus of the RAM port arbiter.
//
// Handshake: a requester raises req[i] with req_we/req_addr/req_wdata and
// keeps all of them stable until it sees gnt[i]; the transfer happens on the
// rising clock edge where req[i] && gnt[i]. gnt[i] never rises without req[i].
// Reads answer with a single rvalid[i] pulse one cycle after the grant, with
// rdata[i] valid in that cycle; rdata[i] holds its value otherwise.
interface dpram_port_arbiter_if;
    import dpram_arb_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [NUM_REQ*DATA_W-1:0] rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/rr_pick.sv
// Circular first-set-bit finder: scans req & mask starting at 'start'.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    input  logic [N-1:0]  mask,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;

    // Walk from the farthest position back to 'start' so the closest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'((int'(start) + k) % N);
            if (req[pos] && mask[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one dual-port RAM between NUM_REQ requesters: up to two grants per
// cycle (A then B in round-robin order), same-address write hazard guard,
// and fixed 1-cycle read return to the originating requester.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    dpram_port_arbiter_if.slave  arb_bus,
    output addr_t                ram_addr_a,
    output addr_t                ram_addr_b,
    output data_t                ram_data_a,
    output data_t                ram_data_b,
    output logic                 ram_we_a,
    output logic                 ram_we_b,
    input  data_t                ram_q_a,
    input  data_t                ram_q_b,
    output idx_t                 dbg_rr_ptr
);

    idx_t               rr_ptr;
    logic               found_a, found_b;
    idx_t               idx_a, idx_b;
    logic [NUM_REQ-1:0] mask_b;
    addr_t              addr_a, addr_b;
    data_t              wdata_a, wdata_b;
    logic               we_a, we_b;
    logic               hazard, grant_a, grant_b;
    addr_t              hold_addr_a, hold_addr_b;
    data_t              hold_data_a, hold_data_b;
    port_tag_t          tag_a, tag_b;
    logic [NUM_REQ-1:0]        rvalid_c;
    logic [NUM_REQ*DATA_W-1:0] rdata_c, rdata_q;

    // Candidate A: first request from rr_ptr. Candidate B: next one after A.
    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick_a (
        .req   (arb_bus.req),
        .start (rr_ptr),
        .mask  ({NUM_REQ{1'b1}}),
        .found (found_a),
        .idx   (idx_a)
    );

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick_b (
        .req   (arb_bus.req),
        .start (rr_ptr),
        .mask  (mask_b),
        .found (found_b),
        .idx   (idx_b)
    );

    // Operand fetch, hazard detection and grant generation (gated by reset).
    always_comb begin
        mask_b  = found_a ? ~idx_onehot(idx_a) : {NUM_REQ{1'b1}};
        addr_a  = arb_bus.req_addr[int'(idx_a)*ADDR_W +: ADDR_W];
        addr_b  = arb_bus.req_addr[int'(idx_b)*ADDR_W +: ADDR_W];
        wdata_a = arb_bus.req_wdata[int'(idx_a)*DATA_W +: DATA_W];
        wdata_b = arb_bus.req_wdata[int'(idx_b)*DATA_W +: DATA_W];
        we_a    = arb_bus.req_we[idx_a];
        we_b    = arb_bus.req_we[idx_b];
        hazard  = found_a && found_b && (addr_a == addr_b) && (we_a || we_b);
        grant_a = found_a && rst_n;
        grant_b = found_b && !hazard && rst_n;
        arb_bus.gnt = (grant_a ? idx_onehot(idx_a) : '0)
                    | (grant_b ? idx_onehot(idx_b) : '0);
    end

    // RAM ports: granted operand passes straight through; idle ports hold addr/data.
    always_comb begin
        ram_we_a   = grant_a && we_a;
        ram_we_b   = grant_b && we_b;
        ram_addr_a = grant_a ? addr_a  : hold_addr_a;
        ram_data_a = grant_a ? wdata_a : hold_data_a;
        ram_addr_b = grant_b ? addr_b  : hold_addr_b;
        ram_data_b = grant_b ? wdata_b : hold_data_b;
    end

    // Remember the last driven address/data of each port for idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_addr_a <= '0;
            hold_data_a <= '0;
            hold_addr_b <= '0;
            hold_data_b <= '0;
        end else begin
            if (grant_a) begin
                hold_addr_a <= addr_a;
                hold_data_a <= wdata_a;
            end
            if (grant_b) begin
                hold_addr_b <= addr_b;
                hold_data_b <= wdata_b;
            end
        end
    end

    // Round-robin pointer moves past the last candidate actually granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_a) begin
            rr_ptr <= idx_inc(grant_b ? idx_b : idx_a);
        end
    end

    // Port tags: which requester, if any, owns the read data of next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_a <= '0;
            tag_b <= '0;
        end else begin
            tag_a <= '{vld: grant_a && !we_a, idx: idx_a};
            tag_b <= '{vld: grant_b && !we_b, idx: idx_b};
        end
    end

    // Read return: rvalid decodes straight from the tag flops; rdata muxes RAM q in.
    always_comb begin
        rvalid_c = '0;
        rdata_c  = rdata_q;
        if (tag_a.vld) begin
            rvalid_c[tag_a.idx] = 1'b1;
            rdata_c[int'(tag_a.idx)*DATA_W +: DATA_W] = ram_q_a;
        end
        if (tag_b.vld) begin
            rvalid_c[tag_b.idx] = 1'b1;
            rdata_c[int'(tag_b.idx)*DATA_W +: DATA_W] = ram_q_b;
        end
    end

    // Keep each requester's last returned word once its rvalid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_c;
        end
    end

    assign arb_bus.rvalid = rvalid_c;
    assign arb_bus.rdata  = rdata_c;
    assign dbg_rr_ptr     = rr_ptr;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural dual-port RAM,
// per-requester expected read queues and a negedge monitor.
module tb_dpram_port_arbiter;
    import dpram_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dpram_port_arbiter_if arb_bus ();

    addr_t ram_addr_a, ram_addr_b;
    data_t ram_data_a, ram_data_b;
    logic  ram_we_a, ram_we_b;
    data_t ram_q_a, ram_q_b;
    idx_t  dbg_rr_ptr;

    dpram_port_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_bus    (arb_bus),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_data_a (ram_data_a),
        .ram_data_b (ram_data_b),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_q_a    (ram_q_a),
        .ram_q_b    (ram_q_b),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // ---------------- RAM model (preloaded during the first reset) ----------------
    logic [7:0] mem [64];
    logic       preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
            mem[5] <= 8'h5A;
            mem[2] <= 8'h3C;
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
        end
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [4][$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every read return is popped and compared; grants must follow requests.
    always @(negedge clk) begin
        chk("gnt_without_req", 32'(arb_bus.gnt & ~arb_bus.req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (arb_bus.rvalid[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("unexpected_rvalid%0d", i), 32'd1, 32'd0);
                end else begin
                    chk($sformatf("rdata%0d", i), 32'(arb_bus.rdata[i*8 +: 8]),
                        32'(exp_q[i].pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    addr_t snap_addr_a, snap_addr_b;
    data_t snap_data_a, snap_data_b;
    logic  snap_we_a, snap_we_b;

    task automatic set_req(input int i, input logic we, input logic [5:0] addr, input logic [7:0] d);
        arb_bus.req[i]              = 1'b1;
        arb_bus.req_we[i]           = we;
        arb_bus.req_addr[i*6 +: 6]  = addr;
        arb_bus.req_wdata[i*8 +: 8] = d;
    endtask

    // One clock: check grant/rvalid mid-cycle, snapshot RAM ports, drop granted requests.
    task automatic cycle(input string name, input logic [3:0] exp_gnt, input logic [3:0] exp_rvalid);
        logic [3:0] g;
        @(negedge clk);
        chk({name, "_gnt"}, 32'(arb_bus.gnt), 32'(exp_gnt));
        chk({name, "_rvalid"}, 32'(arb_bus.rvalid), 32'(exp_rvalid));
        g = arb_bus.gnt;
        snap_addr_a = ram_addr_a; snap_data_a = ram_data_a; snap_we_a = ram_we_a;
        snap_addr_b = ram_addr_b; snap_data_b = ram_data_b; snap_we_b = ram_we_b;
        @(posedge clk);
        #1;
        arb_bus.req = arb_bus.req & ~g;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [5:0] f_addr [4];
    logic [7:0] f_data [4];

    initial begin
        arb_bus.req       = '0;
        arb_bus.req_we    = '0;
        arb_bus.req_addr  = '0;
        arb_bus.req_wdata = '0;
        f_addr[0] = 6'h00; f_data[0] = 8'hAA;
        f_addr[1] = 6'h01; f_data[1] = 8'hCC;
        f_addr[2] = 6'h05; f_data[2] = 8'h5A;
        f_addr[3] = 6'h02; f_data[3] = 8'h3C;

        // Reset held for 3 cycles: everything quiet.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_gnt", 32'(arb_bus.gnt), 32'd0);
            chk("rst_rvalid", 32'(arb_bus.rvalid), 32'd0);
            chk("rst_we", 32'({ram_we_a, ram_we_b}), 32'd0);
            chk("rst_ptr", 32'(dbg_rr_ptr), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        preload = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cycle("idle", 4'b0000, 4'b0000);
            chk("idle_we", 32'({snap_we_a, snap_we_b}), 32'd0);
        end

        // Dual write.
        set_req(0, 1'b1, 6'h00, 8'hAA);
        set_req(1, 1'b1, 6'h01, 8'hBB);
        cycle("dual_wr", 4'b0011, 4'b0000);
        chk("dual_wr_port_a", 32'({snap_addr_a, snap_data_a, snap_we_a}), 32'({6'h00, 8'hAA, 1'b1}));
        chk("dual_wr_port_b", 32'({snap_addr_b, snap_data_b, snap_we_b}), 32'({6'h01, 8'hBB, 1'b1}));
        chk("dual_wr_ptr", 32'(dbg_rr_ptr), 32'd2);

        // Readback of both words.
        set_req(0, 1'b0, 6'h00, 8'h00); exp_q[0].push_back(8'hAA);
        set_req(1, 1'b0, 6'h01, 8'h00); exp_q[1].push_back(8'hBB);
        cycle("readback", 4'b0011, 4'b0000);

        // Single read by req3 brings the pointer back to 0.
        set_req(3, 1'b0, 6'h00, 8'h00); exp_q[3].push_back(8'hAA);
        cycle("align", 4'b1000, 4'b0011);
        chk("align_ptr", 32'(dbg_rr_ptr), 32'd0);

        // Write collision: req0 writes 0x01, req2 reads 0x01.
        set_req(0, 1'b1, 6'h01, 8'hCC);
        set_req(2, 1'b0, 6'h01, 8'h00); exp_q[2].push_back(8'hCC);
        cycle("coll_first", 4'b0001, 4'b1000);
        chk("coll_port_a", 32'({snap_addr_a, snap_data_a, snap_we_a}), 32'({6'h01, 8'hCC, 1'b1}));
        chk("coll_port_b_we", 32'(snap_we_b), 32'd0);
        cycle("coll_second", 4'b0100, 4'b0000);

        // Shared read of 0x05 by req1 and req3.
        set_req(1, 1'b0, 6'h05, 8'h00); exp_q[1].push_back(8'h5A);
        set_req(3, 1'b0, 6'h05, 8'h00); exp_q[3].push_back(8'h5A);
        cycle("shared", 4'b1010, 4'b0100);
        cycle("shared_ret", 4'b0000, 4'b1010);

        // Pointer back to 0 before the fairness run.
        set_req(3, 1'b0, 6'h05, 8'h00); exp_q[3].push_back(8'h5A);
        cycle("align2", 4'b1000, 4'b0000);

        // Round robin: all four hold reads for 8 cycles.
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) set_req(i, 1'b0, f_addr[i], 8'h00);
            if (c % 2 == 0) begin
                exp_q[0].push_back(f_data[0]);
                exp_q[1].push_back(f_data[1]);
            end else begin
                exp_q[2].push_back(f_data[2]);
                exp_q[3].push_back(f_data[3]);
            end
            cycle($sformatf("rr%0d", c), (c % 2 == 0) ? 4'b0011 : 4'b1100,
                  (c == 0) ? 4'b1000 : ((c % 2 == 1) ? 4'b0011 : 4'b1100));
        end
        arb_bus.req = '0;
        cycle("rr_drain", 4'b0000, 4'b1100);

        // Reset right after a read grant: the tag must be discarded.
        set_req(2, 1'b0, 6'h05, 8'h00);
        cycle("mid_gnt", 4'b0100, 4'b0000);
        rst_n = 1'b0;
        arb_bus.req = '0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("mid_rst_rvalid", 32'(arb_bus.rvalid), 32'd0);
            chk("mid_rst_ptr", 32'(dbg_rr_ptr), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle("post_rst", 4'b0000, 4'b0000);
        end
        chk("post_rst_ptr", 32'(dbg_rr_ptr), 32'd0);

        // Every expected read must have come back.
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("exp_q%0d_empty", i), 32'(exp_q[i].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
